// File: rtl/mcb_dat_path_if.sv
// Front-end data bus of the SDRAM data path: write-beat pull and read-beat return.
// Latency: none, this is wiring only.
// Backpressure: none; write beats are popped on request and read beats must be accepted.
interface mcb_dat_path_if #(
    parameter int DQ_W = 16,
    parameter int DM_W = 2
);
    logic            wr_dat_req;
    logic [DQ_W-1:0] wr_dat;
    logic [DM_W-1:0] wr_dm;
    logic            wr_dat_last;
    logic [DQ_W-1:0] rd_dat;
    logic            rd_dat_vld;
    logic            rd_dat_last;

    // Front-end side: supplies write beats, consumes read beats.
    modport master (
        input  wr_dat_req, wr_dat_last, rd_dat, rd_dat_vld, rd_dat_last,
        output wr_dat, wr_dm
    );

    // Data-path side: pops write beats, returns read beats.
    modport slave (
        output wr_dat_req, wr_dat_last, rd_dat, rd_dat_vld, rd_dat_last,
        input  wr_dat, wr_dm
    );
endinterface

// File: rtl/mcb_dat_path.sv
// SDR SDRAM data path: CL/BL counters, IOB-style DQ/DQM drive and read-beat capture.
// Latency: 1 cycle from d_dp_oe to the pads, 1 cycle from d_dp_ie to rd_dat_vld.
// Backpressure: none; write beats are pulled combinationally, read beats are pushed unconditionally.
module mcb_dat_path #(
    parameter int DQ_W       = 16,
    parameter int DM_W       = 2,
    parameter int D_CL_CNT_W = 2,
    parameter int D_BL_CNT_W = 4
) (
    input  logic                  mcb_clk,
    input  logic                  mcb_rst_n,
    input  logic                  mcb_sclr_n,
    input  logic [1:0]            d_bst_num,
    input  logic                  d_cl_cnt_sclr,
    input  logic                  d_bl_cnt_sclr,
    input  logic                  d_dp_ie,
    input  logic                  d_dp_oe,
    output logic [D_CL_CNT_W-1:0] d_cl_cnt,
    output logic [D_BL_CNT_W-1:0] d_bl_cnt,
    mcb_dat_path_if.slave         fe,
    input  logic [DQ_W-1:0]       sdr_dq_i,
    output logic [DQ_W-1:0]       sdr_dq_o,
    output logic                  sdr_dq_oe,
    output logic [DM_W-1:0]       sdr_dqm
);

    logic last_beat;
    logic rd_cap;

    // Final beat of the burst: burst length is (d_bst_num+1)*4, so the last index ends in 2'b11.
    assign last_beat = (d_bl_cnt == D_BL_CNT_W'({d_bst_num, 2'b11}));

    // Write beats are popped in the same cycle the FSM opens a write slot.
    assign fe.wr_dat_req  = d_dp_oe;
    assign fe.wr_dat_last = d_dp_oe & last_beat;

    // A write slot always wins over a simultaneous (illegal) read beat.
    assign rd_cap = d_dp_ie & ~d_dp_oe;

    // CL counter saturates so the FSM can compare against any latency; BL counter wraps.
    always_ff @(posedge mcb_clk or negedge mcb_rst_n) begin
        if (!mcb_rst_n) begin
            d_cl_cnt <= '0;
            d_bl_cnt <= '0;
        end else if (!mcb_sclr_n) begin
            d_cl_cnt <= '0;
            d_bl_cnt <= '0;
        end else begin
            if (d_cl_cnt_sclr)
                d_cl_cnt <= '0;
            else if (d_cl_cnt != '1)
                d_cl_cnt <= d_cl_cnt + D_CL_CNT_W'(1);

            if (d_bl_cnt_sclr)
                d_bl_cnt <= '0;
            else
                d_bl_cnt <= d_bl_cnt + D_BL_CNT_W'(1);
        end
    end

    // Pad output registers: DQ holds between beats, DQM returns to unmasked when not driving.
    always_ff @(posedge mcb_clk or negedge mcb_rst_n) begin
        if (!mcb_rst_n) begin
            sdr_dq_oe <= 1'b0;
            sdr_dq_o  <= '0;
            sdr_dqm   <= '0;
        end else if (!mcb_sclr_n) begin
            sdr_dq_oe <= 1'b0;
            sdr_dq_o  <= '0;
            sdr_dqm   <= '0;
        end else begin
            sdr_dq_oe <= d_dp_oe;
            if (d_dp_oe) begin
                sdr_dq_o <= fe.wr_dat;
                sdr_dqm  <= fe.wr_dm;
            end else begin
                sdr_dqm  <= '0;
            end
        end
    end

    // Read capture: one valid pulse per beat, data holds between beats.
    always_ff @(posedge mcb_clk or negedge mcb_rst_n) begin
        if (!mcb_rst_n) begin
            fe.rd_dat      <= '0;
            fe.rd_dat_vld  <= 1'b0;
            fe.rd_dat_last <= 1'b0;
        end else if (!mcb_sclr_n) begin
            fe.rd_dat      <= '0;
            fe.rd_dat_vld  <= 1'b0;
            fe.rd_dat_last <= 1'b0;
        end else begin
            fe.rd_dat_vld  <= rd_cap;
            fe.rd_dat_last <= rd_cap & last_beat;
            if (rd_cap)
                fe.rd_dat <= sdr_dq_i;
        end
    end

endmodule

// File: tb/tb_mcb_dat_path.sv
module tb_mcb_dat_path;

    logic        mcb_clk = 1'b0;
    logic        mcb_rst_n;
    logic        mcb_sclr_n;
    logic [1:0]  d_bst_num;
    logic        d_cl_cnt_sclr;
    logic        d_bl_cnt_sclr;
    logic        d_dp_ie;
    logic        d_dp_oe;
    logic [1:0]  d_cl_cnt;
    logic [3:0]  d_bl_cnt;
    logic [15:0] sdr_dq_i;
    logic [15:0] sdr_dq_o;
    logic        sdr_dq_oe;
    logic [1:0]  sdr_dqm;

    int checks = 0;
    int errors = 0;

    mcb_dat_path_if #(.DQ_W(16), .DM_W(2)) fe_if ();

    mcb_dat_path #(
        .DQ_W(16), .DM_W(2), .D_CL_CNT_W(2), .D_BL_CNT_W(4)
    ) dut (
        .mcb_clk       (mcb_clk),
        .mcb_rst_n     (mcb_rst_n),
        .mcb_sclr_n    (mcb_sclr_n),
        .d_bst_num     (d_bst_num),
        .d_cl_cnt_sclr (d_cl_cnt_sclr),
        .d_bl_cnt_sclr (d_bl_cnt_sclr),
        .d_dp_ie       (d_dp_ie),
        .d_dp_oe       (d_dp_oe),
        .d_cl_cnt      (d_cl_cnt),
        .d_bl_cnt      (d_bl_cnt),
        .fe            (fe_if.slave),
        .sdr_dq_i      (sdr_dq_i),
        .sdr_dq_o      (sdr_dq_o),
        .sdr_dq_oe     (sdr_dq_oe),
        .sdr_dqm       (sdr_dqm)
    );

    always #5 mcb_clk = ~mcb_clk;

    typedef struct {
        logic        sn, cls, bls, ie, oe;
        logic [1:0]  bst;
        logic [15:0] wd;
        logic [1:0]  wm;
        logic [15:0] dqi;
        logic        e_req, e_wl;
        logic [1:0]  e_cl;
        logic [3:0]  e_bl;
        logic        e_oe;
        logic [15:0] e_dq;
        logic [1:0]  e_dqm;
        logic [15:0] e_rd;
        logic        e_vld, e_rl;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        logic sn, logic [1:0] bst, logic cls, logic bls, logic ie, logic oe,
        logic [15:0] wd, logic [1:0] wm, logic [15:0] dqi,
        logic req, logic wl, logic [1:0] cl, logic [3:0] bl, logic doe,
        logic [15:0] dq, logic [1:0] dqm, logic [15:0] rd, logic vld, logic rl);
        vec_t v;
        v.sn = sn; v.bst = bst; v.cls = cls; v.bls = bls; v.ie = ie; v.oe = oe;
        v.wd = wd; v.wm = wm; v.dqi = dqi;
        v.e_req = req; v.e_wl = wl; v.e_cl = cl; v.e_bl = bl; v.e_oe = doe;
        v.e_dq = dq; v.e_dqm = dqm; v.e_rd = rd; v.e_vld = vld; v.e_rl = rl;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic sn, input logic [1:0] bst, input logic cls, input logic bls,
                         input logic ie, input logic oe, input logic [15:0] wd,
                         input logic [1:0] wm, input logic [15:0] dqi);
        mcb_sclr_n = sn; d_bst_num = bst; d_cl_cnt_sclr = cls; d_bl_cnt_sclr = bls;
        d_dp_ie = ie; d_dp_oe = oe; fe_if.wr_dat = wd; fe_if.wr_dm = wm; sdr_dq_i = dqi;
    endtask

    task automatic chk_regs(input string tag, input logic [1:0] cl, input logic [3:0] bl,
                            input logic doe, input logic [15:0] dq, input logic [1:0] dqm,
                            input logic [15:0] rd, input logic vld, input logic rl);
        chk({tag, " d_cl_cnt"},    32'(d_cl_cnt),          32'(cl));
        chk({tag, " d_bl_cnt"},    32'(d_bl_cnt),          32'(bl));
        chk({tag, " sdr_dq_oe"},   32'(sdr_dq_oe),         32'(doe));
        chk({tag, " sdr_dq_o"},    32'(sdr_dq_o),          32'(dq));
        chk({tag, " sdr_dqm"},     32'(sdr_dqm),           32'(dqm));
        chk({tag, " rd_dat"},      32'(fe_if.rd_dat),      32'(rd));
        chk({tag, " rd_dat_vld"},  32'(fe_if.rd_dat_vld),  32'(vld));
        chk({tag, " rd_dat_last"}, 32'(fe_if.rd_dat_last), 32'(rl));
    endtask

    initial begin
        // ---------------- vector table ----------------
        // sn bst cls bls ie oe  wd  wm  dqi | req wl | cl bl oe dq dqm rd vld rl
        // Test 1: idle after reset, CL saturates at 3, BL keeps counting.
        vecs.push_back(mk(1,0,0,0,0,0,16'h0,0,16'h0, 0,0, 1,1,0,16'h0,0,16'h0,0,0));
        vecs.push_back(mk(1,0,0,0,0,0,16'h0,0,16'h0, 0,0, 2,2,0,16'h0,0,16'h0,0,0));
        vecs.push_back(mk(1,0,0,0,0,0,16'h0,0,16'h0, 0,0, 3,3,0,16'h0,0,16'h0,0,0));
        vecs.push_back(mk(1,0,0,0,0,0,16'h0,0,16'h0, 0,0, 3,4,0,16'h0,0,16'h0,0,0));
        // Test 2: 4-beat write, mask 01 on beat 2.
        vecs.push_back(mk(1,0,1,1,0,0,16'h0,0,16'h0, 0,0, 0,0,0,16'h0,0,16'h0,0,0));
        vecs.push_back(mk(1,0,0,0,0,1,16'h1111,0,16'h0, 1,0, 1,1,1,16'h1111,0,16'h0,0,0));
        vecs.push_back(mk(1,0,0,0,0,1,16'h2222,1,16'h0, 1,0, 2,2,1,16'h2222,1,16'h0,0,0));
        vecs.push_back(mk(1,0,0,0,0,1,16'h3333,0,16'h0, 1,0, 3,3,1,16'h3333,0,16'h0,0,0));
        vecs.push_back(mk(1,0,0,0,0,1,16'h4444,0,16'h0, 1,1, 3,4,1,16'h4444,0,16'h0,0,0));
        vecs.push_back(mk(1,1,1,1,0,0,16'h0,0,16'h0, 0,0, 0,0,0,16'h4444,0,16'h0,0,0));
        // Test 3: 8-beat read, bst_num=1.
        for (int k = 0; k < 8; k++)
            vecs.push_back(mk(1,1,0,0,1,0,16'h0,0,16'hA000 + 16'(k), 0,0,
                              (k >= 2) ? 2'd3 : 2'(k + 1), 4'(k + 1), 0, 16'h4444, 0,
                              16'hA000 + 16'(k), 1, (k == 7)));
        vecs.push_back(mk(1,0,1,1,0,0,16'h0,0,16'h0, 0,0, 0,0,0,16'h4444,0,16'hA007,0,0));
        // Test 4: write then read back to back, BL sclr on the last write beat.
        vecs.push_back(mk(1,0,0,0,0,1,16'h5555,0,16'h0, 1,0, 1,1,1,16'h5555,0,16'hA007,0,0));
        vecs.push_back(mk(1,0,0,0,0,1,16'h6666,2,16'h0, 1,0, 2,2,1,16'h6666,2,16'hA007,0,0));
        vecs.push_back(mk(1,0,0,0,0,1,16'h7777,0,16'h0, 1,0, 3,3,1,16'h7777,0,16'hA007,0,0));
        vecs.push_back(mk(1,0,0,1,0,1,16'h8888,3,16'h0, 1,1, 3,0,1,16'h8888,3,16'hA007,0,0));
        vecs.push_back(mk(1,0,0,0,1,0,16'h0,0,16'hB000, 0,0, 3,1,0,16'h8888,0,16'hB000,1,0));
        vecs.push_back(mk(1,0,0,0,1,0,16'h0,0,16'hB001, 0,0, 3,2,0,16'h8888,0,16'hB001,1,0));
        vecs.push_back(mk(1,0,0,0,1,0,16'h0,0,16'hB002, 0,0, 3,3,0,16'h8888,0,16'hB002,1,0));
        vecs.push_back(mk(1,0,0,0,1,0,16'h0,0,16'hB003, 0,0, 3,4,0,16'h8888,0,16'hB003,1,1));
        vecs.push_back(mk(1,0,1,1,0,0,16'h0,0,16'h0, 0,0, 0,0,0,16'h8888,0,16'hB003,0,0));
        // Test 5: synchronous clear on write beat 2.
        vecs.push_back(mk(1,0,0,0,0,1,16'h9999,0,16'h0, 1,0, 1,1,1,16'h9999,0,16'hB003,0,0));
        vecs.push_back(mk(0,0,0,0,0,1,16'hAAAA,1,16'h0, 1,0, 0,0,0,16'h0,0,16'h0,0,0));
        vecs.push_back(mk(1,0,0,0,0,0,16'h0,0,16'h0, 0,0, 1,1,0,16'h0,0,16'h0,0,0));
        // Test 6: illegal ie&oe with both counter clears.
        vecs.push_back(mk(1,0,1,1,1,1,16'hCCCC,2,16'hDDDD, 1,0, 0,0,1,16'hCCCC,2,16'h0,0,0));
        vecs.push_back(mk(1,0,0,0,0,0,16'h0,0,16'h0, 0,0, 1,1,0,16'hCCCC,0,16'h0,0,0));

        // ---------------- reset state ----------------
        mcb_rst_n = 1'b0;
        drive(1, 0, 0, 0, 0, 0, 16'h0, 0, 16'h0);
        #1;
        chk_regs("reset", 0, 0, 0, 16'h0, 0, 16'h0, 0, 0);
        chk("reset wr_dat_req", 32'(fe_if.wr_dat_req), 0);
        @(posedge mcb_clk);
        @(posedge mcb_clk);
        #1;
        chk_regs("reset held", 0, 0, 0, 16'h0, 0, 16'h0, 0, 0);
        mcb_rst_n = 1'b1;

        // ---------------- table run ----------------
        for (int i = 0; i < vecs.size(); i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            drive(vecs[i].sn, vecs[i].bst, vecs[i].cls, vecs[i].bls, vecs[i].ie,
                  vecs[i].oe, vecs[i].wd, vecs[i].wm, vecs[i].dqi);
            #1;
            chk({tag, " wr_dat_req"},  32'(fe_if.wr_dat_req),  32'(vecs[i].e_req));
            chk({tag, " wr_dat_last"}, 32'(fe_if.wr_dat_last), 32'(vecs[i].e_wl));
            @(posedge mcb_clk);
            #1;
            chk_regs(tag, vecs[i].e_cl, vecs[i].e_bl, vecs[i].e_oe, vecs[i].e_dq,
                     vecs[i].e_dqm, vecs[i].e_rd, vecs[i].e_vld, vecs[i].e_rl);
        end

        // ---------------- sync clear in the middle of a read ----------------
        drive(1, 0, 0, 0, 1, 0, 16'h0, 0, 16'hEEEE);
        @(posedge mcb_clk); #1;
        chk_regs("rdclr beat1", 2, 2, 0, 16'hCCCC, 0, 16'hEEEE, 1, 0);
        drive(0, 0, 0, 0, 1, 0, 16'h0, 0, 16'hEEEF);
        @(posedge mcb_clk); #1;
        chk_regs("rdclr sclr", 0, 0, 0, 16'h0, 0, 16'h0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 16'h0, 0, 16'h0);
        @(posedge mcb_clk); #1;
        chk_regs("rdclr after", 1, 1, 0, 16'h0, 0, 16'h0, 0, 0);

        // ---------------- async reset in the middle of a write ----------------
        drive(1, 0, 0, 0, 0, 1, 16'h1234, 3, 16'h0);
        @(posedge mcb_clk); #1;
        chk_regs("arst beat", 2, 2, 1, 16'h1234, 3, 16'h0, 0, 0);
        #2;
        mcb_rst_n = 1'b0;
        #1;
        chk_regs("arst immediate", 0, 0, 0, 16'h0, 0, 16'h0, 0, 0);
        @(posedge mcb_clk); #1;
        chk_regs("arst held", 0, 0, 0, 16'h0, 0, 16'h0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 16'h0, 0, 16'h0);
        mcb_rst_n = 1'b1;
        @(posedge mcb_clk); #1;
        chk_regs("arst release", 1, 1, 0, 16'h0, 0, 16'h0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
